// File: rtl/clk_gate_seq_pkg.sv
// Shared types and helpers for the clock-gate sequencer: channel FSM states
// and the counter-width function used by every channel.
package clk_gate_seq_pkg;

  typedef enum logic [2:0] {
    CG_ON    = 3'd0,
    CG_DRAIN = 3'd1,
    CG_OFF   = 3'd2,
    CG_WAKE  = 3'd3,
    CG_ABORT = 3'd4
  } cg_state_e;

  // One counter serves both the drain timeout and the wake settle window.
  function automatic int cg_cnt_w(input int settle, input int timeout);
    int longest;
    longest = (settle > timeout) ? settle : timeout;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/clk_gate_ch.sv
// One clock-gate channel: idle handshake FSM, shared drain/settle counter and
// sticky timeout flag. Outputs are registered from the next-state decode.
module clk_gate_ch
  import clk_gate_seq_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_gate,
  input  logic idle_ack,
  input  logic timeout_clr,
  output logic clk_en,
  output logic idle_req,
  output logic timeout,
  output logic busy_nxt
);

  localparam int               CNT_W        = cg_cnt_w(SETTLE_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);

  cg_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             timeout_s, clk_en_s, idle_req_s;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= CG_ON;
      cnt_r    <= CNT_ZERO;
      clk_en   <= 1'b1;
      idle_req <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      clk_en   <= clk_en_s;
      idle_req <= idle_req_s;
      timeout  <= timeout_s;
    end
  end

  // Next-state, counter and sticky-flag decode; a timeout set overrides a clear.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    timeout_s = timeout & ~timeout_clr;
    case (state_r)
      CG_ON: begin
        if (!clk_gate) begin
          state_s = CG_DRAIN;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = CG_ON;
        end
      end
      CG_DRAIN: begin
        if (clk_gate) begin
          state_s = CG_ON;
        end else if (idle_ack) begin
          state_s   = CG_OFF;
          timeout_s = 1'b0;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s   = CG_ABORT;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      CG_OFF: begin
        if (clk_gate) begin
          state_s = CG_WAKE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = CG_OFF;
        end
      end
      CG_WAKE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = CG_ON;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      CG_ABORT: begin
        if (clk_gate) begin
          state_s = CG_ON;
        end else begin
          state_s = CG_ABORT;
        end
      end
      default: begin
        state_s = CG_ON;
        cnt_s   = CNT_ZERO;
      end
    endcase
    clk_en_s   = (state_s != CG_OFF);
    idle_req_s = (state_s == CG_DRAIN) | (state_s == CG_OFF) | (state_s == CG_WAKE);
    busy_nxt   = (state_s == CG_DRAIN) | (state_s == CG_WAKE);
  end

endmodule

// File: rtl/clk_gate_seq.sv
// Clock-gate sequencer top: one handshake channel per peripheral plus the
// registered any-channel-busy flag.
module clk_gate_seq
  import clk_gate_seq_pkg::*;
#(
  parameter int N_CH        = 32,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [N_CH-1:0] clk_gate_i,
  input  logic [N_CH-1:0] idle_ack_i,
  input  logic            timeout_clr_i,
  output logic [N_CH-1:0] clk_en_o,
  output logic [N_CH-1:0] idle_req_o,
  output logic [N_CH-1:0] timeout_o,
  output logic            busy_o
);

  logic [N_CH-1:0] busy_nxt_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_gate_ch #(
      .SETTLE_CYC (SETTLE_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk        (HCLK),
      .rst        (HRESET),
      .clk_gate   (clk_gate_i[g]),
      .idle_ack   (idle_ack_i[g]),
      .timeout_clr(timeout_clr_i),
      .clk_en     (clk_en_o[g]),
      .idle_req   (idle_req_o[g]),
      .timeout    (timeout_o[g]),
      .busy_nxt   (busy_nxt_s[g])
    );
  end

  // Busy is built from next-state so it lines up with the channel outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      busy_o <= 1'b0;
    end else begin
      busy_o <= |busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_clk_gate_seq.sv
// Directed bench for clk_gate_seq: stimulus queues expected outputs, a
// negedge monitor pops and compares them.
module tb_clk_gate_seq;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] clk_gate_i, idle_ack_i;
  logic        timeout_clr_i;
  logic [31:0] clk_en_o, idle_req_o, timeout_o;
  logic        busy_o;

  typedef struct {
    string       name;
    logic [31:0] ce;
    logic [31:0] ir;
    logic [31:0] to;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ce_e, ir_e, to_e;
  logic        busy_e;
  int          total = 0;
  int          bad   = 0;

  clk_gate_seq #(.N_CH(32), .SETTLE_CYC(4), .TIMEOUT_CYC(256)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .clk_gate_i   (clk_gate_i),
    .idle_ack_i   (idle_ack_i),
    .timeout_clr_i(timeout_clr_i),
    .clk_en_o     (clk_en_o),
    .idle_req_o   (idle_req_o),
    .timeout_o    (timeout_o),
    .busy_o       (busy_o)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  always @(negedge HCLK) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (clk_en_o !== e.ce || idle_req_o !== e.ir || timeout_o !== e.to || busy_o !== e.busy) begin
        bad++;
        $display("FAIL %s: got ce=%h ir=%h to=%h busy=%b want ce=%h ir=%h to=%h busy=%b",
                 e.name, clk_en_o, idle_req_o, timeout_o, busy_o, e.ce, e.ir, e.to, e.busy);
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string name);
    exp_q.push_back('{name, ce_e, ir_e, to_e, busy_e});
  endtask

  // Gate a channel that never acks; DRAIN lasts exactly 256 cycles.
  task automatic drain_timeout(input int ch, input bit clr_last);
    clk_gate_i[ch] = 1'b0;
    tick();
    ir_e[ch] = 1'b1; busy_e = 1'b1; chk("to_drain");
    repeat (255) tick();
    chk("to_drain_last");
    timeout_clr_i = clr_last;
    tick();
    timeout_clr_i = 1'b0;
    ir_e[ch] = 1'b0; to_e[ch] = 1'b1; busy_e = 1'b0; chk("to_abort");
  endtask

  initial begin
    HRESET = 1'b1; clk_gate_i = 32'hFFFF_FFFF; idle_ack_i = 32'h0000_0000; timeout_clr_i = 1'b0;
    ce_e = 32'hFFFF_FFFF; ir_e = 32'h0000_0000; to_e = 32'h0000_0000; busy_e = 1'b0;
    tick(); tick();
    chk("reset");
    HRESET = 1'b0;
    repeat (10) begin tick(); chk("t1_idle"); end

    // ch3 drain then ack
    clk_gate_i[3] = 1'b0;
    tick(); ir_e[3] = 1'b1; busy_e = 1'b1; chk("t2_drain");
    repeat (4) begin tick(); chk("t2_wait"); end
    idle_ack_i[3] = 1'b1;
    tick(); ce_e[3] = 1'b0; busy_e = 1'b0; chk("t2_off");
    idle_ack_i[3] = 1'b0;
    tick(); chk("t2_off_hold");

    // ch3 wake with settle window
    clk_gate_i[3] = 1'b1;
    tick(); ce_e[3] = 1'b1; busy_e = 1'b1; chk("t3_wake_clk");
    repeat (3) begin tick(); chk("t3_settle"); end
    tick(); ir_e[3] = 1'b0; busy_e = 1'b0; chk("t3_on");

    // ch7 timeout, clear, set-beats-clear, ack-clears
    drain_timeout(7, 1'b0);
    tick(); chk("t4_abort_hold");
    timeout_clr_i = 1'b1;
    tick(); timeout_clr_i = 1'b0; to_e[7] = 1'b0; chk("t4_clr");
    clk_gate_i[7] = 1'b1;
    tick(); chk("t4_on");
    drain_timeout(7, 1'b1);
    clk_gate_i[7] = 1'b1;
    tick(); chk("t4b_sticky_on");
    clk_gate_i[7] = 1'b0;
    tick(); ir_e[7] = 1'b1; busy_e = 1'b1; chk("t4c_drain");
    idle_ack_i[7] = 1'b1;
    tick(); ce_e[7] = 1'b0; to_e[7] = 1'b0; busy_e = 1'b0; chk("t4c_off_clears");
    idle_ack_i[7] = 1'b0; clk_gate_i[7] = 1'b1;
    tick(); ce_e[7] = 1'b1; busy_e = 1'b1; chk("t4c_wake");
    repeat (3) tick();
    tick(); ir_e[7] = 1'b0; busy_e = 1'b0; chk("t4c_on");

    // ch0 ack and gate=1 together: abort wins
    clk_gate_i[0] = 1'b0;
    tick(); ir_e[0] = 1'b1; busy_e = 1'b1; chk("t5_drain");
    idle_ack_i[0] = 1'b1; clk_gate_i[0] = 1'b1;
    tick(); ir_e[0] = 1'b0; busy_e = 1'b0; chk("t5_abort_wins");
    idle_ack_i[0] = 1'b0;
    tick(); chk("t5_on_hold");
    // ch0 gate toggled low during WAKE
    clk_gate_i[0] = 1'b0;
    tick(); ir_e[0] = 1'b1; busy_e = 1'b1; chk("t5_drain2");
    idle_ack_i[0] = 1'b1;
    tick(); ce_e[0] = 1'b0; busy_e = 1'b0; chk("t5_off");
    idle_ack_i[0] = 1'b0; clk_gate_i[0] = 1'b1;
    tick(); ce_e[0] = 1'b1; busy_e = 1'b1; chk("t5_wake");
    clk_gate_i[0] = 1'b0;
    repeat (3) begin tick(); chk("t5_wake_ignores_gate"); end
    tick(); ir_e[0] = 1'b0; busy_e = 1'b0; chk("t5_on_again");
    tick(); ir_e[0] = 1'b1; busy_e = 1'b1; chk("t5_redrain");
    clk_gate_i[0] = 1'b1;
    tick(); ir_e[0] = 1'b0; busy_e = 1'b0; chk("t5_back_on");

    // reset mid-flight: ch7 ABORT, ch2 OFF, ch5 DRAIN
    drain_timeout(7, 1'b0);
    clk_gate_i[2] = 1'b0;
    tick(); ir_e[2] = 1'b1; busy_e = 1'b1; chk("t6_ch2_drain");
    idle_ack_i[2] = 1'b1;
    tick(); ce_e[2] = 1'b0; busy_e = 1'b0; chk("t6_ch2_off");
    idle_ack_i[2] = 1'b0; clk_gate_i[5] = 1'b0;
    tick(); ir_e[5] = 1'b1; busy_e = 1'b1; chk("t6_ch5_drain");
    HRESET = 1'b1; clk_gate_i = 32'hFFFF_FFFF;
    tick(); ce_e = 32'hFFFF_FFFF; ir_e = 32'h0000_0000; to_e = 32'h0000_0000; busy_e = 1'b0;
    chk("t6_reset");
    HRESET = 1'b0;
    tick(); chk("t6_after_reset");

    tick(); tick();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
